beta_irq_ctl: RTL and testbench

//  Multi-channel interrupt controller for the Beta core; replaces the single IRQ pin into CTL.

---
 rtl/beta_pkg.sv | 11 +
 rtl/beta_prio_enc.sv | 22 ++
 rtl/beta_irq_ctl.sv | 101 ++++++++++
 tb/tb_beta_irq_ctl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// rtl/beta_pkg.sv - shared Beta core types and constants for the interrupt controller
package beta_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SVC  = 1'b1
    } irq_state_t;

    localparam logic [31:0] XADR = 32'h8000_0008;

endpackage

// File: rtl/beta_prio_enc.sv
// rtl/beta_prio_enc.sv - lowest-index-wins priority encoder
module beta_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [3:0]   index
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        index = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = 4'(i);
            end
        end
    end

endmodule

// File: rtl/beta_irq_ctl.sv
// rtl/beta_irq_ctl.sv - multi-channel masked fixed-priority interrupt controller for CTL
module beta_irq_ctl
    import beta_pkg::*;
#(
    parameter int                 NUM_IRQ    = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '0,
    parameter logic [31:0]        VEC_BASE   = XADR,
    parameter int                 VEC_STRIDE = 4
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_IRQ-1:0] IRQ_IN,
    input  logic               MASK_WE,
    input  logic [NUM_IRQ-1:0] MASK_WD,
    input  logic [NUM_IRQ-1:0] OVF_CLR,
    input  logic               SUPERVISOR,
    input  logic               IRQ_ACK,
    input  logic               IRQ_DONE,
    output logic               IRQ_REQ,
    output logic [31:0]        IRQ_VEC,
    output logic [3:0]         IRQ_ID,
    output logic [NUM_IRQ-1:0] PENDING,
    output logic [NUM_IRQ-1:0] OVF
);

    localparam logic [31:0] STRIDE = 32'(VEC_STRIDE);

    irq_state_t         state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] ovf_q, ovf_d;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic               win_valid;
    logic [3:0]         winner;
    logic               take;
    logic [3:0]         id_q;

    assign eligible = pending_q & mask_q;

    beta_prio_enc #(.N(NUM_IRQ)) u_prio (
        .req   (eligible),
        .valid (win_valid),
        .index (winner)
    );

    assign IRQ_REQ = (state_q == ST_IDLE) && win_valid && !SUPERVISOR;
    assign take    = IRQ_REQ && IRQ_ACK;
    // Only edge channels are consumed by an acknowledge; level channels follow their source.
    assign clr     = take ? ((NUM_IRQ'(1) << winner) & EDGE_MASK) : '0;
    assign IRQ_VEC = take ? (VEC_BASE + 32'(winner) * STRIDE) : 32'd0;

    // Per-channel capture: level channels mirror the source, edge channels latch rising edges.
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
        if (EDGE_MASK[i]) begin : g_edge
            logic rise;
            assign rise         = IRQ_IN[i] & ~prev_q[i];
            assign pending_d[i] = (pending_q[i] & ~clr[i]) | rise;
            // A second edge lands on a still-pending (or just-consumed) request: one was lost.
            assign ovf_d[i]     = (ovf_q[i] & ~OVF_CLR[i]) | (rise & (pending_q[i] | clr[i]));
        end else begin : g_level
            assign pending_d[i] = IRQ_IN[i];
            assign ovf_d[i]     = ovf_q[i] & ~OVF_CLR[i];
        end
    end

    // Next-state: acknowledge enters service, handler return leaves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (take)     state_d = ST_SVC;
            ST_SVC:  if (IRQ_DONE) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // State, mask, capture registers and the in-service channel.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            prev_q    <= '0;
            id_q      <= 4'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            prev_q    <= IRQ_IN;
            if (MASK_WE) mask_q <= MASK_WD;
            if (take)    id_q   <= winner;
        end
    end

    assign IRQ_ID  = id_q;
    assign PENDING = pending_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_beta_irq_ctl.sv
// tb/tb_beta_irq_ctl.sv - scoreboard testbench for beta_irq_ctl
module tb_beta_irq_ctl;

    localparam int N = 8;

    typedef struct packed {
        logic [31:0] vec;
        logic [3:0]  id;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] irq_in, mask_wd, ovf_clr;
    logic         mask_we, sup, ack, done;
    logic         irq_req;
    logic [31:0]  irq_vec;
    logic [3:0]   irq_id;
    logic [N-1:0] pending, ovf;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    beta_irq_ctl #(
        .NUM_IRQ    (N),
        .EDGE_MASK  (8'h26),
        .VEC_BASE   (32'h8000_0008),
        .VEC_STRIDE (4)
    ) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .IRQ_IN     (irq_in),
        .MASK_WE    (mask_we),
        .MASK_WD    (mask_wd),
        .OVF_CLR    (ovf_clr),
        .SUPERVISOR (sup),
        .IRQ_ACK    (ack),
        .IRQ_DONE   (done),
        .IRQ_REQ    (irq_req),
        .IRQ_VEC    (irq_vec),
        .IRQ_ID     (irq_id),
        .PENDING    (pending),
        .OVF        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ack(input logic [3:0] id);
        sb_q.push_back('{vec: 32'h8000_0008 + 32'(id) * 32'd4, id: id});
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    // Monitor: every accepted acknowledge pops one expected vector, then checks the latched ID.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack && irq_req) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ack_vec", irq_vec, e.vec);
                    @(posedge clk);
                    #1;
                    chk("svc_id", {28'd0, irq_id}, {28'd0, e.id});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wd = '0; ovf_clr = '0;
        sup = 1'b0; ack = 1'b0; done = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        chk("rst_req", {31'd0, irq_req}, 32'd0);
        chk("rst_pend", {24'd0, pending}, 32'd0);
        chk("rst_ovf", {24'd0, ovf}, 32'd0);
        chk("rst_id", {28'd0, irq_id}, 32'd0);
        chk("rst_vec", irq_vec, 32'd0);

        mask_we = 1'b1; mask_wd = 8'hFF; cyc(); mask_we = 1'b0;

        // Level channel 3
        irq_in = 8'h08; cyc();
        chk("t1_req", {31'd0, irq_req}, 32'd1);
        chk("t1_pend", {24'd0, pending}, 32'h08);
        do_ack(4'd3);
        chk("t1_svc_req", {31'd0, irq_req}, 32'd0);
        irq_in = 8'h00; done = 1'b1; cyc(); done = 1'b0;
        chk("t1_idle_req", {31'd0, irq_req}, 32'd0);

        // Edge channels 5 and 2 together: 2 wins, then 5
        irq_in = 8'h24; cyc();
        chk("t2_pend", {24'd0, pending}, 32'h24);
        chk("t2_req", {31'd0, irq_req}, 32'd1);
        do_ack(4'd2);
        chk("t2_pend_after", {24'd0, pending}, 32'h20);
        done = 1'b1; cyc(); done = 1'b0;
        chk("t2_req2", {31'd0, irq_req}, 32'd1);
        do_ack(4'd5);
        chk("t2_pend_empty", {24'd0, pending}, 32'h00);
        done = 1'b1; cyc(); done = 1'b0;
        irq_in = 8'h00; cyc();

        // Supervisor mode blocks requests
        sup = 1'b1; irq_in = 8'h01; cyc();
        chk("t3_sup_req", {31'd0, irq_req}, 32'd0);
        chk("t3_pend", {24'd0, pending}, 32'h01);
        sup = 1'b0; #1;
        chk("t3_user_req", {31'd0, irq_req}, 32'd1);
        do_ack(4'd0);
        irq_in = 8'h00; done = 1'b1; cyc(); done = 1'b0;

        // Two edges on channel 1 before service: overflow, single service
        irq_in = 8'h02; cyc();
        irq_in = 8'h00; cyc();
        irq_in = 8'h02; cyc();
        chk("t4_ovf", {24'd0, ovf}, 32'h02);
        chk("t4_pend", {24'd0, pending}, 32'h02);
        irq_in = 8'h00;
        do_ack(4'd1);
        done = 1'b1; cyc(); done = 1'b0;
        chk("t4_pend_after", {24'd0, pending}, 32'h00);
        chk("t4_req_after", {31'd0, irq_req}, 32'd0);
        ovf_clr = 8'h02; cyc(); ovf_clr = 8'h00;
        chk("t4_ovf_clr", {24'd0, ovf}, 32'h00);

        // Reset during service
        irq_in = 8'h08; cyc();
        do_ack(4'd3);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk("t5_req", {31'd0, irq_req}, 32'd0);
        chk("t5_pend", {24'd0, pending}, 32'h00);
        chk("t5_id", {28'd0, irq_id}, 32'd0);
        cyc();
        chk("t5_masked_req", {31'd0, irq_req}, 32'd0);
        ack = 1'b1; cyc(); ack = 1'b0;
        chk("t5_ign_id", {28'd0, irq_id}, 32'd0);
        mask_we = 1'b1; mask_wd = 8'hFF; cyc(); mask_we = 1'b0;
        chk("t5_remask_req", {31'd0, irq_req}, 32'd1);
        do_ack(4'd3);
        done = 1'b1; cyc(); done = 1'b0;

        // Mask cleared in the acknowledge cycle: old mask still applies
        chk("t6_req", {31'd0, irq_req}, 32'd1);
        mask_we = 1'b1; mask_wd = 8'h00;
        do_ack(4'd3);
        mask_we = 1'b0;
        done = 1'b1; cyc(); done = 1'b0;
        chk("t6_req_masked", {31'd0, irq_req}, 32'd0);
        chk("t6_pend_kept", {24'd0, pending}, 32'h08);
        irq_in = 8'h00; cyc(); cyc();

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
